// File: rtl/core_pkg.sv
// Shared core types and constants: datapath width, reset PC, fetch entry layout and
// fetch FSM encoding.
package core_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries.
// The head entry is read straight from the storage registers.
module fetch_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wrData,
  output fetch_entry_t headData,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  rdPtr;
  logic [PW-1:0]  wrPtr;
  logic [CW-1:0]  count;
  logic           doPush;
  logic           doPop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign doPop    = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign doPush   = push & (~full | doPop);
  assign headData = mem[rdPtr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= wrData;
        wrPtr      <= wrPtr + 1'b1;
      end
      if (doPop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      unique case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC and the IDLE/RUN fetch FSM, captures
// {pc, instr} into a FIFO feeding decode, and flushes on redirect.
module instr_fetch
  import core_pkg::*;
#(
  parameter int              XLEN     = core_pkg::XLEN,
  parameter int              IMEM_AW  = 6,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [XLEN-1:0]    if_pc,
  output logic [31:0]        if_instr,
  output logic               misalign_err,
  output fetch_state_t       dbgState
);

  // Handshake: an entry moves to decode on a cycle where if_valid and if_ready are
  // both high; if_valid never drops without a transfer except on redirect/reset.

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic            pop;
  logic            push;
  logic            fifoFull;
  logic            fifoEmpty;
  fetch_entry_t    wrEntry;
  fetch_entry_t    head;

  assign imem_addr = pc[IMEM_AW+1:2];
  assign if_valid  = ~fifoEmpty;
  assign if_pc     = head.pc;
  assign if_instr  = head.instr;
  assign dbgState  = state;

  assign pop     = if_valid & if_ready;
  assign push    = (state == RUN) & fetch_en & ~redirect_valid & (~fifoFull | pop);
  assign wrEntry = '{pc: pc, instr: imem_rdata};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      misalign_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (fetch_en)  state <= RUN;
        RUN:  if (!fetch_en) state <= IDLE;
        default:             state <= IDLE;
      endcase
      // Redirect wins over sequential advance, in either state.
      if (redirect_valid) begin
        pc <= {redirect_pc[XLEN-1:2], 2'b00};
        if (redirect_pc[1:0] != 2'b00) misalign_err <= 1'b1;
      end else if (push) begin
        pc <= pc + XLEN'(4);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .flush    (redirect_valid),
    .wrData   (wrEntry),
    .headData (head),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: scenario tasks checked against a queue-based model of the
// fetch stage.
module tb_instr_fetch;
  import core_pkg::*;

  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         fetch_en = 1'b0;
  logic [5:0]   imem_addr;
  logic [31:0]  imem_rdata;
  logic         redirect_valid = 1'b0;
  logic [31:0]  redirect_pc = '0;
  logic         if_valid;
  logic         if_ready = 1'b0;
  logic [31:0]  if_pc;
  logic [31:0]  if_instr;
  logic         misalign_err;
  fetch_state_t dbgState;

  logic [31:0] imem [64];
  assign imem_rdata = imem[imem_addr];

  // Model state: pending {pc,instr} entries, PC, running flag, sticky error.
  logic [63:0] exp_q[$];
  logic [31:0] mPc;
  bit          mRun;
  bit          mErr;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  instr_fetch #(
    .XLEN     (32),
    .IMEM_AW  (6),
    .RESET_PC (32'h0000_0000),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .misalign_err   (misalign_err),
    .dbgState       (dbgState)
  );

  task automatic fill_mem_pattern();
    for (int k = 0; k < 64; k++) imem[k] = 32'h1000_0000 + k;
  endtask

  // Advance one clock; the model applies the same input set seen at that edge.
  task automatic tick();
    bit          doPop;
    bit          doPush;
    logic [63:0] entry;
    doPop  = (exp_q.size() != 0) && if_ready;
    doPush = mRun && fetch_en && !redirect_valid && ((exp_q.size() < DEPTH) || doPop);
    entry  = {mPc, imem[mPc[7:2]]};
    @(posedge clk);
    #1;
    if (redirect_valid) begin
      exp_q.delete();
      mPc = {redirect_pc[31:2], 2'b00};
      if (redirect_pc[1:0] != 2'b00) mErr = 1'b1;
    end else begin
      if (doPop) void'(exp_q.pop_front());
      if (doPush) begin
        exp_q.push_back(entry);
        mPc = mPc + 32'd4;
      end
    end
    mRun = fetch_en;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    fill_mem_pattern();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    mPc  = 32'h0;
    mRun = 1'b0;
    mErr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    fill_mem_pattern();
    repeat (2) @(negedge clk);
    compared++; if (if_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b want 0", if_valid); end
    compared++; if (if_pc !== 32'h0) begin mismatched++; $display("FAIL reset_pc: got %h want 0", if_pc); end
    compared++; if (if_instr !== 32'h0) begin mismatched++; $display("FAIL reset_instr: got %h want 0", if_instr); end
    compared++; if (misalign_err !== 1'b0) begin mismatched++; $display("FAIL reset_err: got %b want 0", misalign_err); end
    compared++; if (imem_addr !== 6'd0) begin mismatched++; $display("FAIL reset_addr: got %0d want 0", imem_addr); end
    compared++; if (dbgState !== IDLE) begin mismatched++; $display("FAIL reset_state: got %0d want IDLE", dbgState); end
    @(posedge clk); #1;
    do_reset();
  endtask

  task automatic test_sequential();
    do_reset();
    fetch_en = 1'b1;
    if_ready = 1'b1;
    tick();
    compared++; if (if_valid !== 1'b0) begin mismatched++; $display("FAIL seq_idle_bubble: got %b want 0", if_valid); end
    for (int i = 0; i < 5; i++) begin
      tick();
      compared++;
      if (if_valid !== 1'b1 || if_pc !== 32'(4 * i) || if_instr !== 32'h1000_0000 + i) begin
        mismatched++;
        $display("FAIL seq_%0d: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                 i, if_valid, if_pc, if_instr, 32'(4 * i), 32'h1000_0000 + i);
      end
    end
  endtask

  task automatic test_backpressure();
    int nextPc;
    do_reset();
    fetch_en = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      compared++; if (if_pc !== 32'h0) begin mismatched++; $display("FAIL bp_hold_pc: got %h want 0", if_pc); end
    end
    compared++; if (exp_q.size() != 2 || if_valid !== 1'b1) begin mismatched++; $display("FAIL bp_full: got v=%b model=%0d want 2", if_valid, exp_q.size()); end
    compared++; if (imem_addr !== 6'd2) begin mismatched++; $display("FAIL bp_pc_stop: got %0d want 2", imem_addr); end
    if_ready = 1'b1;
    nextPc = 0;
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (if_valid !== 1'b1 || if_pc !== 32'(nextPc) || if_instr !== 32'h1000_0000 + nextPc / 4) begin
        mismatched++;
        $display("FAIL bp_order_%0d: got v=%b pc=%h want pc=%h", i, if_valid, if_pc, 32'(nextPc));
      end
      nextPc += 4;
      tick();
    end
  endtask

  task automatic test_redirect();
    do_reset();
    fetch_en = 1'b1;
    repeat (3) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    redirect_valid = 1'b0;
    compared++; if (if_valid !== 1'b0) begin mismatched++; $display("FAIL redir_bubble: got %b want 0", if_valid); end
    tick();
    compared++;
    if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_instr !== 32'h1000_0010) begin
      mismatched++;
      $display("FAIL redir_target: got v=%b pc=%h instr=%h want v=1 pc=40 instr=10000010", if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_redirect_pop();
    do_reset();
    fetch_en = 1'b1;
    repeat (3) tick();
    if_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h43;
    tick();
    redirect_valid = 1'b0;
    if_ready       = 1'b0;
    compared++; if (if_valid !== 1'b0) begin mismatched++; $display("FAIL rpop_flush: got %b want 0", if_valid); end
    compared++; if (imem_addr !== 6'h10) begin mismatched++; $display("FAIL rpop_pc: got %h want 10", imem_addr); end
    compared++; if (misalign_err !== 1'b1) begin mismatched++; $display("FAIL rpop_err: got %b want 1", misalign_err); end
    tick();
    compared++; if (if_pc !== 32'h40) begin mismatched++; $display("FAIL rpop_head: got %h want 40", if_pc); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    tick();
    redirect_valid = 1'b0;
    repeat (3) tick();
    compared++; if (misalign_err !== 1'b1) begin mismatched++; $display("FAIL rpop_sticky: got %b want 1", misalign_err); end
    compared++; if (if_pc !== mPc - 32'd8 && if_pc !== 32'h80) begin mismatched++; $display("FAIL rpop_after: got %h", if_pc); end
  endtask

  task automatic test_wrap();
    bit sawWrap;
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFC;
    tick();
    redirect_valid = 1'b0;
    compared++; if (imem_addr !== 6'd63) begin mismatched++; $display("FAIL wrap_start: got %0d want 63", imem_addr); end
    fetch_en = 1'b1;
    if_ready = 1'b1;
    tick();
    tick();
    compared++; if (imem_addr !== 6'd0) begin mismatched++; $display("FAIL wrap_addr: got %0d want 0", imem_addr); end
    sawWrap = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (if_valid && if_pc == 32'h100) begin
        sawWrap = 1'b1;
        compared++; if (if_instr !== 32'h1000_0000) begin mismatched++; $display("FAIL wrap_instr: got %h want 10000000", if_instr); end
      end
      compared++;
      if (if_valid !== (exp_q.size() != 0) || (exp_q.size() != 0 && {if_pc, if_instr} !== exp_q[0])) begin
        mismatched++;
        $display("FAIL wrap_model_%0d: got v=%b pc=%h instr=%h", i, if_valid, if_pc, if_instr);
      end
    end
    compared++; if (!sawWrap) begin mismatched++; $display("FAIL wrap_seen: got none want pc=100"); end
  endtask

  task automatic test_async_reset();
    do_reset();
    fetch_en = 1'b1;
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    compared++; if (if_valid !== 1'b0) begin mismatched++; $display("FAIL areset_valid: got %b want 0", if_valid); end
    compared++; if (imem_addr !== 6'd0) begin mismatched++; $display("FAIL areset_pc: got %0d want 0", imem_addr); end
    @(posedge clk); #1;
    exp_q.delete();
    mPc = 32'h0; mRun = 1'b0; mErr = 1'b0;
    fetch_en = 1'b0;
    rst_n = 1'b1;
    repeat (2) tick();
    compared++; if (if_valid !== 1'b0) begin mismatched++; $display("FAIL areset_nofetch: got %b want 0", if_valid); end
    fetch_en = 1'b1;
    if_ready = 1'b1;
    tick();
    compared++; if (if_valid !== 1'b0) begin mismatched++; $display("FAIL areset_idle_step: got %b want 0", if_valid); end
    tick();
    compared++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin mismatched++; $display("FAIL areset_restart: got v=%b pc=%h want v=1 pc=0", if_valid, if_pc); end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 64; k++) imem[k] = $urandom;
    for (int i = 0; i < 400; i++) begin
      fetch_en       = ($urandom_range(0, 9) != 0);
      if_ready       = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom & 32'h0000_03FF;
      tick();
      compared++;
      if (if_valid !== (exp_q.size() != 0)) begin
        mismatched++;
        $display("FAIL rand_valid_%0d: got %b want %b", i, if_valid, exp_q.size() != 0);
      end
      if (exp_q.size() != 0) begin
        compared++;
        if ({if_pc, if_instr} !== exp_q[0]) begin
          mismatched++;
          $display("FAIL rand_head_%0d: got %h_%h want %h", i, if_pc, if_instr, exp_q[0]);
        end
      end
      compared++;
      if (imem_addr !== mPc[7:2] || misalign_err !== mErr) begin
        mismatched++;
        $display("FAIL rand_pc_%0d: got addr=%0d err=%b want addr=%0d err=%b", i, imem_addr, misalign_err, mPc[7:2], mErr);
      end
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_redirect_pop();
    test_wrap();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
